// File: rtl/cla_serial_subtractor_pkg.sv
// Shared definitions for the serial carry-lookahead subtractor.
package cla_serial_subtractor_pkg;

    // Controller states: waiting for operands, slicing, and holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits handled by the lookahead slice in each cycle.
    localparam int SLICE_W = 4;

    // Number of cycles (slices) needed to cover an operand of the given width.
    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_serial_subtractor_cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module cla4_slice
    import cla_serial_subtractor_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    // Per-bit generate/propagate terms and sum bits.
    genvar gi;
    generate
        for (gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign g[gi] = x[gi] & y[gi];
            assign p[gi] = x[gi] ^ y[gi];
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Flattened lookahead carries; no carry ripples from bit to bit.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign co   = c[4];

endmodule

// File: rtl/cla_serial_subtractor.sv
// Serial subtractor: a - b - bin computed as a + ~b + ~bin, one 4-bit
// lookahead slice per cycle, LSB first, with valid/ready handshakes.
module cla_serial_subtractor
    import cla_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, diff_reg;
    logic [CW-1:0]      cnt_reg;
    logic               carry_reg;
    logic               a_msb_reg, b_msb_reg;
    logic               bout_reg, ovf_reg;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               accept;
    logic               last_slice;

    assign accept     = in_valid && in_ready;
    assign last_slice = (state_reg == CALC) && (cnt_reg == LAST_SLICE);

    // Operand registers shift right so the current slice is always bits [3:0].
    cla4_slice u_slice (
        .x  (a_reg[SLICE_W-1:0]),
        .y  (~b_reg[SLICE_W-1:0]),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; illegal encodings fall back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (cnt_reg == LAST_SLICE) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then fold one slice per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ~bin;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            cnt_reg   <= '0;
        end else if (state_reg == CALC) begin
            a_reg     <= a_reg >> SLICE_W;
            b_reg     <= b_reg >> SLICE_W;
            diff_reg  <= {slice_s, diff_reg[WIDTH-1:SLICE_W]};
            carry_reg <= slice_co;
            cnt_reg   <= cnt_reg + CW'(1);
            if (last_slice) begin
                // Carry out of an a + ~b add is the inverse of the borrow.
                bout_reg <= ~slice_co;
                ovf_reg  <= (a_msb_reg != b_msb_reg) &&
                            (slice_s[SLICE_W-1] != a_msb_reg);
            end
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;
    assign zero      = out_valid && (diff_reg == '0);

endmodule

// File: tb/tb_cla_serial_subtractor.sv
// Directed and randomised checks of the serial subtractor at WIDTH=16.
module tb_cla_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int errors = 0;
    int checks = 0;

    cla_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to #1 after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the block is ready for operands.
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("rdy_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one operation, check latency and result, optionally consume it.
    task automatic run_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                          input logic obin, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez, input bit consume);
        int lat;
        wait_ready();
        a = oa; b = ob; bin = obin; in_valid = 1'b1;
        step();
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = ~obin;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"},   32'(lat),      32'd5);
        chk({tag, "_diff"},  32'(diff),     32'(ed));
        chk({tag, "_bout"},  32'(bout),     32'(eb));
        chk({tag, "_ovf"},   32'(ovf),      32'(eo));
        chk({tag, "_zero"},  32'(zero),     32'(ez));
        chk({tag, "_irdy"},  32'(in_ready), 32'd0);
        $display("op %s a=%04h b=%04h bin=%0d -> diff=%04h bout=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, oa, ob, obin, diff, bout, ovf, zero, lat);
        if (consume) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk({tag, "_ovld_after"}, 32'(out_valid), 32'd0);
            chk({tag, "_irdy_after"}, 32'(in_ready),  32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, ed, held;
        logic        rbin, eb, eo;
        int          hs, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        step();
        step();
        chk("rst_irdy", 32'(in_ready),  32'd1);
        chk("rst_ovld", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff),      32'd0);
        chk("rst_bout", 32'(bout),      32'd0);
        chk("rst_ovf",  32'(ovf),       32'd0);
        chk("rst_zero", 32'(zero),      32'd0);
        $display("reset done");
        rst = 1'b0;
        step();

        // Directed vectors with hand-computed results.
        run_op("sub5_3",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub0_1",    16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("ovf_neg",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("zero_bin",  16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("wrap_zero", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("ovf_pos",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-pressure: result held for 10 cycles while a new request is offered.
        run_op("hold", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        held = diff;
        for (int i = 0; i < 10; i++) begin
            a = 16'hFFFF; b = 16'h0001; bin = 1'b1; in_valid = 1'b1;
            step();
            chk("hold_ovld", 32'(out_valid), 32'd1);
            chk("hold_irdy", 32'(in_ready),  32'd0);
            chk("hold_diff", 32'(diff),      32'(held));
            chk("hold_bout", 32'(bout),      32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold_done_irdy", 32'(in_ready),  32'd1);
        step();
        chk("hold_noacc_irdy", 32'(in_ready),  32'd1);
        chk("hold_noacc_ovld", 32'(out_valid), 32'd0);
        $display("hold test done");

        // Reset during the second CALC cycle aborts the operation.
        wait_ready();
        a = 16'h1111; b = 16'h0101; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_irdy", 32'(in_ready),  32'd1);
        chk("abort_ovld", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff),      32'd0);
        chk("abort_zero", 32'(zero),      32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_quiet", 32'(out_valid), 32'd0);
        end
        $display("abort test done");
        run_op("post_abort", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0, 1'b0, 1'b1);

        // Random operations with random consumer back-pressure.
        for (int n = 0; n < 200; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            {eb, ed} = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            eo = (ra[15] != rb[15]) && (ed[15] != ra[15]);
            wait_ready();
            a = ra; b = rb; bin = rbin; in_valid = 1'b1;
            step();
            in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
            hs = 0;
            cyc = 0;
            while (hs == 0 && cyc < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    chk("rnd_diff", 32'(diff), 32'(ed));
                    chk("rnd_bout", 32'(bout), 32'(eb));
                    chk("rnd_ovf",  32'(ovf),  32'(eo));
                    chk("rnd_zero", 32'(zero), 32'(ed == 16'h0000));
                    hs++;
                end
                step();
                cyc++;
            end
            out_ready = 1'b0;
            chk("rnd_hs",   32'(hs),        32'd1);
            chk("rnd_drop", 32'(out_valid), 32'd0);
            $display("rnd %0d a=%04h b=%04h bin=%0d exp diff=%04h bout=%0d ovf=%0d",
                     n, ra, rb, rbin, ed, eb, eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_serial_subtractor.md
CLA_SERIAL_SUBTRACTOR -- requirements
Module: cla_serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 with WIDTH >= 8.
REQ-002 SHALL have the following ports, one per line:
  clk        input   1      single clock; all state updates on rising edge
  rst        input   1      reset; synchronous, active-high
  in_valid   input   1      operand set valid
  in_ready   output  1      block can accept an operand set
  a          input   WIDTH  minuend
  b          input   WIDTH  subtrahend
  bin        input   1      borrow-in, for chaining wider subtractions
  out_valid  output  1      result valid
  out_ready  input   1      consumer accepts result
  diff       output  WIDTH  a - b - bin, modulo 2^WIDTH
  bout       output  1      borrow-out; 1 when unsigned a < b + bin
  ovf        output  1      two's-complement signed overflow of the subtraction
  zero       output  1      diff == 0

Function
REQ-003 SHALL compute diff = a + ~b + ~bin, processed as 4-bit carry-lookahead slices.
REQ-004 SHALL process one 4-bit slice per cycle, LSB slice first.
REQ-005 SHALL set the slice-0 carry-in to ~bin.
REQ-006 SHALL set each later slice's carry-in to the registered carry-out of the previous slice.
REQ-007 SHALL use the FSM states IDLE, CALC and DONE.
REQ-008 SHALL assert in_ready only in IDLE, and SHALL never assert in_ready while out_valid = 1.
REQ-009 SHALL register a, b and bin, clear the slice counter, and move IDLE -> CALC on any cycle where in_valid && in_ready; a, b and bin are ignored at all other times.
REQ-010 SHALL, in CALC, write one slice per cycle into the diff register, increment the slice counter, and move to DONE after slice WIDTH/4-1.
REQ-011 SHALL assert out_valid exactly in DONE, giving latency WIDTH/4+1 cycles from the accept edge to out_valid (5 cycles for WIDTH=16).
REQ-012 SHALL hold diff, bout, ovf and zero stable while out_valid = 1.
REQ-013 SHALL move DONE -> IDLE on any cycle where out_valid && out_ready; no new operand is accepted in that same cycle, so back-to-back throughput is 1 result per WIDTH/4+2 cycles.
REQ-014 SHALL, if out_ready is held low, stay in DONE indefinitely and leave every output unchanged.
REQ-015 SHALL compute bout = ~(final carry-out).
REQ-016 SHALL compute ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-017 SHALL compute zero combinationally from the diff register, qualified by out_valid (zero = 0 when out_valid = 0).
REQ-018 SHALL ignore in_valid in CALC and DONE; holding in_valid high there SHALL NOT corrupt the operation in progress.
REQ-019 SHALL have no unreachable state; any illegal state encoding returns to IDLE on the next edge.

Reset
REQ-020 SHALL, on rst = 1 at a clock edge, go to IDLE and drive in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0, slice counter = 0.
REQ-021 SHALL abort an operation in progress when rst is asserted mid-CALC or in DONE, with no result presented afterwards.
REQ-022 SHALL give rst priority over in_valid and out_ready in the same cycle.

Structure
REQ-023 SHALL place in a shared package: the FSM state encoding (IDLE, CALC, DONE), the slice width constant (4), and a function returning the slice count for WIDTH.
REQ-024 SHALL implement the per-cycle arithmetic as one combinational sub-module, cla4_slice: inputs x[3:0], y[3:0], ci; outputs s[3:0], co; generate/propagate lookahead equations.
REQ-025 SHALL have no combinational path from a, b or bin to any output.

Verification (WIDTH=16)
REQ-026 SHALL cover: a=0x0005, b=0x0003, bin=0 -> after 5 cycles diff=0x0002, bout=0, ovf=0, zero=0.
REQ-027 SHALL cover: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0.
REQ-028 SHALL cover: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1; and a=0x1234, b=0x1233, bin=1 -> diff=0x0000, zero=1, bout=0.
REQ-029 SHALL cover: out_ready held low 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; a new in_valid pulse in that window is not accepted.
REQ-030 SHALL cover: rst asserted on the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, diff=0; a following operation a=0x00FF, b=0x0F00 gives diff=0xF1FF, bout=1.
REQ-031 SHALL cover: 200 random back-to-back operations with random out_ready -> every result matches the reference model (a-b-bin) and each result is accepted exactly once.
